// File: rtl/mux3_rr_arbiter_if.sv
// Bundle of the requester-side and consumer-side signals of mux3_rr_arbiter.
// The arbiter takes the slave view; whoever drives requests and consumes
// data_out takes the master view.
interface mux3_rr_arbiter_if #(
  parameter int W = 32
);
  // Requester side: one request bit and one data word per channel
  logic [2:0]   req;
  logic [W-1:0] ch_0;
  logic [W-1:0] ch_1;
  logic [W-1:0] ch_2;
  logic [2:0]   ack;

  // Consumer side: registered word with valid/ready handshake
  logic [W-1:0] data_out;
  logic         out_valid;
  logic         out_ready;

  // Status
  logic [1:0]   select;
  logic         busy;

  modport slave (
    input  req,
    input  ch_0,
    input  ch_1,
    input  ch_2,
    input  out_ready,
    output select,
    output data_out,
    output out_valid,
    output ack,
    output busy
  );

  modport master (
    output req,
    output ch_0,
    output ch_1,
    output ch_2,
    output out_ready,
    input  select,
    input  data_out,
    input  out_valid,
    input  ack,
    input  busy
  );
endinterface

// File: rtl/mux3_rr_arbiter.sv
// Round-robin arbiter sharing one W-bit 3:1 mux among three requesters.
// One word is granted, registered and offered downstream with valid/ready;
// the requester whose word was accepted gets a single-cycle ack. Sequence is
// IDLE (arbitrate) -> XFER (hold word until ready) -> ACK (pulse ack).
module mux3_rr_arbiter #(
  parameter int W = 32
) (
  input  logic                clk,
  input  logic                rst,
  mux3_rr_arbiter_if.slave    bus
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_XFER = 2'b01;
  localparam logic [1:0] ST_ACK  = 2'b10;

  // Channel 2 was "last served" out of reset so channel 0 is first in line.
  localparam logic [1:0] LAST_GRANT_RST = 2'b10;

  logic [1:0]   state_reg,      state_next;
  logic [1:0]   last_grant_reg, last_grant_next;
  logic [1:0]   select_reg,     select_next;
  logic [W-1:0] data_reg,       data_next;
  logic         valid_reg,      valid_next;
  logic [2:0]   ack_reg,        ack_next;

  // Candidate channels in service order after last_grant, their request
  // bits, and the one-hot decode of the current select.
  logic [1:0]   cand_idx [3];
  logic [2:0]   cand_req;
  logic [2:0]   sel_onehot;
  logic         grant_any;
  logic [1:0]   grant_idx;
  logic [W-1:0] grant_data;

  // (base + k) mod 3 for base in 0..2 and k in 1..3
  function automatic logic [1:0] rr_step(input logic [1:0] base, input logic [1:0] k);
    logic [2:0] sum;
    sum = {1'b0, base} + {1'b0, k};
    if (sum >= 3'd3) begin
      sum = sum - 3'd3;
    end
    return sum[1:0];
  endfunction

  // Request bit of a channel index; index 3 is never a channel
  function automatic logic chan_req(input logic [1:0] idx, input logic [2:0] r);
    logic hit;
    case (idx)
      2'd0:    hit = r[0];
      2'd1:    hit = r[1];
      2'd2:    hit = r[2];
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  // Candidate order: last_grant+1, last_grant+2, last_grant (all mod 3)
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cand
      assign cand_idx[gi]   = rr_step(last_grant_reg, 2'(gi + 1));
      assign cand_req[gi]   = chan_req(cand_idx[gi], bus.req);
      assign sel_onehot[gi] = (select_reg == 2'(gi));
    end
  endgenerate

  // Priority pick among the rotated candidates
  always_comb begin
    grant_any = |cand_req;
    if (cand_req[0]) begin
      grant_idx = cand_idx[0];
    end else if (cand_req[1]) begin
      grant_idx = cand_idx[1];
    end else begin
      grant_idx = cand_idx[2];
    end
  end

  // The shared 3:1 datapath mux driven by the grant encoding
  always_comb begin
    case (grant_idx)
      2'd0:    grant_data = bus.ch_0;
      2'd1:    grant_data = bus.ch_1;
      2'd2:    grant_data = bus.ch_2;
      default: grant_data = '0;
    endcase
  end

  // Sequencer next-state: arbitrate in IDLE, hold in XFER, pulse in ACK
  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    select_next     = select_reg;
    data_next       = data_reg;
    valid_next      = valid_reg;
    ack_next        = 3'b000;

    case (state_reg)
      ST_IDLE: begin
        valid_next = 1'b0;
        if (grant_any) begin
          select_next = grant_idx;
          data_next   = grant_data;
          valid_next  = 1'b1;
          state_next  = ST_XFER;
        end
      end

      ST_XFER: begin
        // Word and select are frozen; req/ch_* are not looked at here.
        valid_next = 1'b1;
        if (valid_reg && bus.out_ready) begin
          valid_next      = 1'b0;
          ack_next        = sel_onehot;
          last_grant_next = select_reg;
          state_next      = ST_ACK;
        end
      end

      ST_ACK: begin
        // ack drops via the default; no arbitration this cycle.
        state_next = ST_IDLE;
      end

      default: begin
        valid_next = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
  end

  // State registers; reset discards any pending word without an ack
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= LAST_GRANT_RST;
      select_reg     <= 2'b00;
      data_reg       <= '0;
      valid_reg      <= 1'b0;
      ack_reg        <= 3'b000;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      select_reg     <= select_next;
      data_reg       <= data_next;
      valid_reg      <= valid_next;
      ack_reg        <= ack_next;
    end
  end

  assign bus.select    = select_reg;
  assign bus.data_out  = data_reg;
  assign bus.out_valid = valid_reg;
  assign bus.ack       = ack_reg;
  assign bus.busy      = (state_reg != ST_IDLE);

endmodule

// File: doc/mux3_rr_arbiter.md
Name: mux3_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one W-bit 3-to-1 datapath mux among three requesters (e.g. the X/Y/Z CORDIC operand sources feeding a single shared adder/FPU port).
- Grants one requester at a time and drives the mux select with the 00/01/10 encoding.
- Registers the selected word and presents it to a single downstream consumer with a valid/ready handshake.
- Returns a one-cycle acknowledge to the requester whose word was accepted.

Parameters:
- W, 32, data width of each channel and of data_out.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  3  request per channel; req[i] is held high until ack[i].
- ch_0  input  W  data of requester 0; valid while req[0] is high.
- ch_1  input  W  data of requester 1; valid while req[1] is high.
- ch_2  input  W  data of requester 2; valid while req[2] is high.
- out_ready  input  1  downstream consumer can accept data_out this cycle.
- select  output  2  registered mux select of the current grant: 00=ch_0, 01=ch_1, 10=ch_2; 11 never driven.
- data_out  output  W  registered selected word.
- out_valid  output  1  data_out holds an unaccepted word.
- ack  output  3  one-hot, one-cycle pulse to the requester whose word was transferred.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, active-high; overrides everything, including mid-transfer):
  - select=00, data_out=0, out_valid=0, ack=000, busy=0, state=IDLE.
  - last_grant=10, so ch_0 has first priority after reset.
  - A word pending at reset is discarded and receives no ack.
- States: IDLE, XFER, ACK.
- IDLE:
  - If req==000, stay in IDLE; outputs hold, out_valid=0.
  - Otherwise pick the first set req bit in the order last_grant+1, last_grant+2, last_grant (mod 3).
  - On the next edge: select<=grant encoding, data_out<=that channel's data, out_valid<=1, state<=XFER.
- XFER:
  - out_valid=1; data_out and select are stable and ignore changes on req and ch_*.
  - When out_valid && out_ready: out_valid<=0, ack[select]<=1, last_grant<=select, state<=ACK.
  - If out_ready stays low, hold indefinitely. There is no timeout.
- ACK:
  - ack is high for exactly this cycle; no arbitration happens in this cycle.
  - Next edge: ack<=000, state<=IDLE.
  - A requester must deassert req, or present new data, by the edge that ends ACK.
  - req sampled in the following IDLE cycle is treated as a new request.
- Throughput: at most one word per 3 cycles.
  - Latency from req seen in IDLE to out_valid: 1 cycle.
  - Latency from handshake to ack: 1 cycle.
- Simultaneous requests: resolved purely by the round-robin order. Each active requester is served at most once per round.
- A req that drops while its word is in XFER is ignored; the transfer still completes and ack still pulses.
- select holds its last value in IDLE and ACK. It changes only on the IDLE->XFER edge.
- busy = (state != IDLE).

Test Plan:
1. Reset, then req=001, ch_0=0x3F800000, out_ready=1 -> out_valid=1 and select=00 one cycle after req; data_out=0x3F800000; ack=001 the cycle after the handshake; back to IDLE with busy=0.
2. req=111 held, ch_0=0xA, ch_1=0xB, ch_2=0xC, out_ready=1, each requester re-requests after its ack -> grant order ch_0, ch_1, ch_2, ch_0; select sequence 00, 01, 10, 00; new out_valid every 3 cycles.
3. Backpressure: grant ch_1 with out_ready=0 for 5 cycles while ch_1 changes to 0xDEAD -> out_valid stays 1, data_out keeps the originally latched value, no ack; ack=010 one cycle after out_ready rises.
4. Fairness after last_grant=01 with req=101 -> ch_2 granted first (select=10), then ch_0.
5. Assert rst in XFER with out_valid=1 -> next cycle out_valid=0, ack=000, select=00, data_out=0; a subsequent req=111 grants ch_0 first.
6. req dropped to 000 during XFER -> transfer still completes on out_ready; ack pulses for the granted channel; no new grant afterwards.
